// File: rtl/heat_column_writer_pkg.sv
// Shared heat-map definitions: column geometry, colour width, the column
// writer FSM encodings and a row range helper. Used by the plotting master,
// generate_grid and every column writer so they agree on sizes and states.
package heat_column_writer_pkg;

   localparam int HM_ROWS        = 480;
   localparam int HM_COLOR_W     = 8;
   localparam int HM_ROW_W       = 10;
   localparam int HM_COLS        = 64;
   localparam int HM_MEM_DEPTH   = 512;
   localparam int HM_MEM_ADDR_W  = 9;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;
   localparam logic [1:0] ST_CLEAR = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_WRITE = ST_WRITE,
      S_ACK   = ST_ACK,
      S_CLEAR = ST_CLEAR
   } col_state_t;

   function automatic logic row_in_range(input logic [HM_ROW_W-1:0] row, input int rows);
      return (int'(row) < rows);
   endfunction

endpackage

// File: rtl/M10K_512_8.sv
// Simple dual-port block RAM, one write port and one registered read port.
// A read and a write to the same address in one cycle returns the old word.
// No reset on the array: contents are only defined after software clears it.
//   i_clock    rising-edge clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address, sampled every cycle
//   o_rd_data  word at i_rd_addr, one cycle later
module M10K_512_8 #(
   parameter int DEPTH  = 512,
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 9
) (
   input  logic              i_clock,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge i_clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/heat_column_writer.sv
// One heat-map column: accepts plot writes from the plotting master over a
// four-phase col_select/return_sig handshake, sweeps the column to zero on
// clear_req, and serves the VGA scan-out through an independent read port.
// generate_grid instantiates one of these per column.
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   col_select   plot request, held until acknowledged
//   row_select   target row of the request
//   pixel_color  colour of the request
//   return_sig   write acknowledge
//   clear_req    one-cycle pulse, zero the whole column
//   busy         high while the clear sweep runs
//   vga_row      scan row to read
//   vga_color    colour of vga_row, two cycles later (0 outside the column)
//
// state | meaning
// IDLE  | waiting; a pending clear wins over a new plot request
// WRITE | one-cycle memory write at the latched row (suppressed if off-column)
// ACK   | return_sig held until the master drops col_select
// CLEAR | zero rows 0..ROWS-1, one per cycle, busy high
module heat_column_writer
   import heat_column_writer_pkg::*;
#(
   parameter int ROWS    = HM_ROWS,
   parameter int COLOR_W = HM_COLOR_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               col_select,
   input  logic [9:0]         row_select,
   input  logic [COLOR_W-1:0] pixel_color,
   output logic               return_sig,
   input  logic               clear_req,
   output logic               busy,
   input  logic [9:0]         vga_row,
   output logic [COLOR_W-1:0] vga_color
);

   localparam int ADDR_W = HM_MEM_ADDR_W;
   localparam int DEPTH  = HM_MEM_DEPTH;

   if (ROWS > DEPTH || ROWS < 1) begin : g_rows_check
      $error("heat_column_writer: ROWS must be between 1 and the RAM depth");
   end

   col_state_t         r_state;
   col_state_t         w_state_nxt;
   logic [9:0]         r_row;
   logic [COLOR_W-1:0] r_color;
   logic               r_return_sig;
   logic               w_return_nxt;
   logic               r_clr_pend;
   logic               w_clr_pend_nxt;
   logic [ADDR_W-1:0]  r_clr_row;
   logic [ADDR_W-1:0]  w_clr_row_nxt;
   logic               w_latch;
   logic               w_we;
   logic               w_mem_we;
   logic [ADDR_W-1:0]  w_waddr;
   logic [COLOR_W-1:0] w_wdata;
   logic [COLOR_W-1:0] w_rd_data;
   logic               r_vga_oor;
   logic [COLOR_W-1:0] r_vga_color;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_return_sig <= 1'b0;
         r_clr_pend   <= 1'b0;
         r_clr_row    <= '0;
         r_row        <= '0;
         r_color      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_return_sig <= w_return_nxt;
         r_clr_pend   <= w_clr_pend_nxt;
         r_clr_row    <= w_clr_row_nxt;
         if (w_latch) begin
            r_row   <= row_select;
            r_color <= pixel_color;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_return_nxt   = r_return_sig;
      w_clr_pend_nxt = r_clr_pend;
      w_clr_row_nxt  = r_clr_row;
      w_latch        = 1'b0;
      w_we           = 1'b0;
      w_waddr        = r_row[ADDR_W-1:0];
      w_wdata        = r_color;
      case (r_state)
         S_IDLE: begin
            w_return_nxt = 1'b0;
            if (clear_req || r_clr_pend) begin
               w_state_nxt    = S_CLEAR;
               w_clr_pend_nxt = 1'b0;
               w_clr_row_nxt  = '0;
            end else if (col_select) begin
               w_latch     = 1'b1;
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            // Off-column rows still run the full handshake, they just never
            // reach the RAM.
            w_we        = row_in_range(r_row, ROWS);
            w_state_nxt = S_ACK;
            if (clear_req) begin
               w_clr_pend_nxt = 1'b1;
            end
         end
         S_ACK: begin
            if (clear_req) begin
               w_clr_pend_nxt = 1'b1;
            end
            if (col_select) begin
               w_return_nxt = 1'b1;
            end else begin
               w_return_nxt = 1'b0;
               w_state_nxt  = S_IDLE;
            end
         end
         S_CLEAR: begin
            w_we    = 1'b1;
            w_waddr = r_clr_row;
            w_wdata = '0;
            if (int'(r_clr_row) == ROWS - 1) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_clr_row_nxt = r_clr_row + ADDR_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The RAM has no reset, so the strobe is gated here to make reset abort
   // any write scheduled for the same edge.
   assign w_mem_we = w_we & ~reset;

   M10K_512_8 #(
      .DEPTH  (DEPTH),
      .WIDTH  (COLOR_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .i_clock   (clock),
      .i_wr_en   (w_mem_we),
      .i_wr_addr (w_waddr),
      .i_wr_data (w_wdata),
      .i_rd_addr (vga_row[ADDR_W-1:0]),
      .o_rd_data (w_rd_data)
   );

   // The out-of-range flag travels alongside the RAM read register so the
   // output stage knows whether to pass the word or force zero. Resetting it
   // high masks the unreset RAM read register right after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_vga_oor   <= 1'b1;
         r_vga_color <= '0;
      end else begin
         r_vga_oor   <= ~row_in_range(vga_row, ROWS);
         r_vga_color <= r_vga_oor ? '0 : w_rd_data;
      end
   end

   assign return_sig = r_return_sig;
   assign busy       = (r_state == S_CLEAR);
   assign vga_color  = r_vga_color;

endmodule

// File: tb/tb_heat_column_writer.sv
module tb_heat_column_writer;
   import heat_column_writer_pkg::*;

   localparam int ROWS    = 480;
   localparam int COLOR_W = 8;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               col_select = 1'b0;
   logic [9:0]         row_select = '0;
   logic [COLOR_W-1:0] pixel_color = '0;
   logic               return_sig;
   logic               clear_req = 1'b0;
   logic               busy;
   logic [9:0]         vga_row = '0;
   logic [COLOR_W-1:0] vga_color;

   heat_column_writer #(.ROWS(ROWS), .COLOR_W(COLOR_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .col_select  (col_select),
      .row_select  (row_select),
      .pixel_color (pixel_color),
      .return_sig  (return_sig),
      .clear_req   (clear_req),
      .busy        (busy),
      .vga_row     (vga_row),
      .vga_color   (vga_color)
   );

   initial forever #5 clock = ~clock;

   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   exp_rd_q[$];
   int   exp_rise_q[$];
   int   exp_fall_q[$];
   int   exp_busy_q[$];
   logic rd_tag = 1'b0;
   logic rd_p1 = 1'b0;
   logic rd_p2 = 1'b0;
   logic prev_ret = 1'b0;
   logic prev_busy = 1'b0;
   int   busy_start = 0;
   int   mon_e;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endtask

   task automatic note_fail(input string name);
      n_total++;
      $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
   endtask

   // cycle count and read-valid pipeline, matching the DUT's two-cycle read
   initial forever begin
      @(posedge clock);
      cyc++;
      rd_p2 = rd_p1;
      rd_p1 = rd_tag;
   end

   // scoreboard monitor
   initial forever begin
      @(negedge clock);
      if (rd_p2) begin
         if (exp_rd_q.size() == 0) note_fail("vga_rd_unexpected");
         else begin
            mon_e = exp_rd_q.pop_front();
            check("vga_rd", int'(vga_color), mon_e);
         end
      end
      if (return_sig && !prev_ret) begin
         if (exp_rise_q.size() == 0) note_fail("ack_rise_unexpected");
         else begin
            mon_e = exp_rise_q.pop_front();
            check("ack_rise_cycle", cyc, mon_e);
         end
      end
      if (!return_sig && prev_ret) begin
         if (exp_fall_q.size() == 0) note_fail("ack_fall_unexpected");
         else begin
            mon_e = exp_fall_q.pop_front();
            check("ack_fall_cycle", cyc, mon_e);
         end
      end
      if (busy && !prev_busy) busy_start = cyc;
      if (!busy && prev_busy) begin
         if (exp_busy_q.size() == 0) note_fail("busy_unexpected");
         else begin
            mon_e = exp_busy_q.pop_front();
            check("busy_cycles", cyc - busy_start, mon_e);
         end
      end
      prev_ret  = return_sig;
      prev_busy = busy;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_ret(input logic val, input int budget);
      int n = 0;
      while (return_sig !== val && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (return_sig !== val) note_fail("ack_timeout");
   endtask

   task automatic wait_busy_low(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (busy) note_fail("busy_timeout");
   endtask

   task automatic wr(input int row, input int color);
      exp_rise_q.push_back(cyc + 3);
      col_select  = 1'b1;
      row_select  = 10'(row);
      pixel_color = 8'(color);
      @(negedge clock);
      wait_ret(1'b1, 20);
      col_select = 1'b0;
      exp_fall_q.push_back(cyc + 1);
      @(negedge clock);
   endtask

   task automatic rd(input int row, input int exp);
      vga_row = 10'(row);
      rd_tag  = 1'b1;
      exp_rd_q.push_back(exp);
      @(negedge clock);
      rd_tag = 1'b0;
   endtask

   task automatic clear_pulse(input int dur);
      exp_busy_q.push_back(dur);
      clear_req = 1'b1;
      @(negedge clock);
      clear_req = 1'b0;
   endtask

   int c0;

   initial begin
      repeat (3) @(negedge clock);
      check("rst_return_sig", int'(return_sig), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_vga_color", int'(vga_color), 0);
      reset = 1'b0;
      @(negedge clock);

      clear_pulse(ROWS);
      wait_busy_low(600);

      // basic handshake and readback
      wr(5, 'hFF);
      rd(5, 'hFF);
      wr(0, 'h01);
      wr(479, 'h7E);
      wr(100, 'hC3);
      rd(0, 'h01);
      rd(479, 'h7E);
      rd(100, 'hC3);
      rd(6, 0);

      // off-column rows: handshake completes, nothing stored
      wr(500, 'h55);
      wr(480, 'h66);
      rd(500, 0);
      rd(480, 0);
      rd(1023, 0);
      rd(5, 'hFF);
      rd(479, 'h7E);

      // same-row read/write collision returns old data first
      exp_rise_q.push_back(cyc + 3);
      col_select  = 1'b1;
      row_select  = 10'd5;
      pixel_color = 8'h3C;
      rd(5, 'hFF);
      rd(5, 'hFF);
      rd(5, 'h3C);
      wait_ret(1'b1, 20);
      col_select = 1'b0;
      exp_fall_q.push_back(cyc + 1);
      @(negedge clock);

      // clear sweep
      wr(0, 'hAA);
      wr(100, 'hAA);
      wr(479, 'hAA);
      clear_pulse(ROWS);
      wait_busy_low(600);
      rd(0, 0);
      rd(100, 0);
      rd(479, 0);
      rd(5, 0);

      // clear during ACK with a queued write behind it
      c0 = cyc;
      exp_rise_q.push_back(c0 + 3);
      col_select  = 1'b1;
      row_select  = 10'd10;
      pixel_color = 8'h11;
      repeat (2) @(negedge clock);
      clear_req = 1'b1;
      @(negedge clock);
      clear_req = 1'b0;
      wait_ret(1'b1, 20);
      col_select = 1'b0;
      exp_fall_q.push_back(cyc + 1);
      @(negedge clock);
      exp_busy_q.push_back(ROWS);
      exp_rise_q.push_back(cyc + 484);
      col_select  = 1'b1;
      row_select  = 10'd20;
      pixel_color = 8'h22;
      repeat (50) @(negedge clock);
      clear_req = 1'b1;   // ignored while sweeping
      @(negedge clock);
      clear_req = 1'b0;
      wait_ret(1'b1, 600);
      col_select = 1'b0;
      exp_fall_q.push_back(cyc + 1);
      @(negedge clock);
      repeat (3) @(negedge clock);
      rd(20, 'h22);
      rd(10, 0);

      // reset while the sweep is at row 200
      wr(199, 'hAA);
      wr(200, 'hAA);
      wr(479, 'hAA);
      repeat (3) @(negedge clock);
      exp_busy_q.push_back(201);
      clear_req = 1'b1;
      @(negedge clock);
      clear_req = 1'b0;
      repeat (200) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("mid_clear_rst_return_sig", int'(return_sig), 0);
      check("mid_clear_rst_busy", int'(busy), 0);
      check("mid_clear_rst_vga_color", int'(vga_color), 0);
      reset = 1'b0;
      @(negedge clock);
      rd(199, 0);
      rd(200, 'hAA);
      rd(479, 'hAA);
      rd(0, 0);

      repeat (5) @(negedge clock);
      check("rd_queue_drained", exp_rd_q.size(), 0);
      check("rise_queue_drained", exp_rise_q.size(), 0);
      check("fall_queue_drained", exp_fall_q.size(), 0);
      check("busy_queue_drained", exp_busy_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
